tl_a_param_queue: RTL and testbench

//  Parametrised TileLink A-channel FIFO replacing fixed 2-entry, fixed-field queues. Buffers full A beats
//  (opcode/param/size/source/address/mask/data/corrupt) between a client port and the crossbar.

---
 rtl/tl_a_param_queue_pkg.sv | 45 ++++
 rtl/tl_a_param_queue_if.sv | 34 +++
 rtl/tl_a_param_queue_ram.sv | 29 ++
 rtl/tl_a_param_queue.sv | 146 ++++++++++++++
 tb/tb_tl_a_param_queue.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/tl_a_param_queue_pkg.sv
// tl_a_param_queue_pkg
//  Shared TileLink A-channel definitions for the parametrised A-channel queue:
//  default field widths, the A opcode encoding, a packed beat struct for the
//  default configuration and width helpers used to size storage and pointers.
//  No ports (package).
package tl_a_param_queue_pkg;

  localparam int TL_ADDR_W   = 33;
  localparam int TL_SOURCE_W = 3;
  localparam int TL_DATA_W   = 64;
  localparam int TL_MASK_W   = TL_DATA_W / 8;

  typedef enum logic [2:0] {
    TL_PUT_FULL    = 3'd0,
    TL_PUT_PARTIAL = 3'd1,
    TL_ARITH       = 3'd2,
    TL_LOGIC       = 3'd3,
    TL_GET         = 3'd4,
    TL_HINT        = 3'd5,
    TL_ACQUIRE     = 3'd6
  } tl_a_opcode_e;

  // Field order here is the packing order used for queue storage.
  typedef struct packed {
    logic [2:0]             opcode;
    logic [2:0]             param;
    logic [2:0]             size;
    logic [TL_SOURCE_W-1:0] source;
    logic [TL_ADDR_W-1:0]   address;
    logic [TL_MASK_W-1:0]   mask;
    logic [TL_DATA_W-1:0]   data;
    logic                   corrupt;
  } a_chan_t;

  // Total bits in one flattened A beat for a given field configuration.
  function automatic int tl_a_beat_w(input int addr_w, input int source_w, input int data_w);
    return 3 + 3 + 3 + source_w + addr_w + (data_w / 8) + data_w + 1;
  endfunction

  // Pointer width; a single-entry queue still gets a 1-bit (constant) pointer.
  function automatic int tl_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tl_a_param_queue_if.sv
// tl_a_param_queue_if
//  One TileLink A-channel port: valid/ready handshake plus all beat fields.
//  master: drives valid and the beat fields, receives ready.
//  slave : receives valid and the beat fields, drives ready.
interface tl_a_param_queue_if
  import tl_a_param_queue_pkg::*;
#(
  parameter int ADDR_W   = TL_ADDR_W,
  parameter int SOURCE_W = TL_SOURCE_W,
  parameter int DATA_W   = TL_DATA_W
) ();

  logic                  valid;
  logic                  ready;
  logic [2:0]            opcode;
  logic [2:0]            param;
  logic [2:0]            size;
  logic [SOURCE_W-1:0]   source;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W/8-1:0]   mask;
  logic [DATA_W-1:0]     data;
  logic                  corrupt;

  modport master (
    output valid, opcode, param, size, source, address, mask, data, corrupt,
    input  ready
  );

  modport slave (
    input  valid, opcode, param, size, source, address, mask, data, corrupt,
    output ready
  );

endinterface

// File: rtl/tl_a_param_queue_ram.sv
// tl_a_param_queue_ram
//  DEPTH x WIDTH flop array: one synchronous write port, one asynchronous read.
//  Contents are deliberately not reset; validity is tracked by the queue.
//  Ports: clock, we_i/waddr_i/wdata_i (write), raddr_i/rdata_o (read).
module tl_a_param_queue_ram #(
  parameter int DEPTH  = 2,
  parameter int WIDTH  = 1,
  parameter int ADDR_W = 1
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage write port.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tl_a_param_queue.sv
// tl_a_param_queue
//  TileLink A-channel FIFO with configurable depth, optional flow-through
//  (FLOW) and pipe (PIPE) behaviour, registered occupancy count and a
//  synchronous flush.
//  Ports: clock, reset (async, active-high), io_flush (sync discard),
//         io_enq (slave A port from client), io_deq (master A port to
//         crossbar), io_count (entries held).
module tl_a_param_queue
  import tl_a_param_queue_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int ADDR_W   = TL_ADDR_W,
  parameter int SOURCE_W = TL_SOURCE_W,
  parameter int DATA_W   = TL_DATA_W,
  parameter bit FLOW     = 1'b0,
  parameter bit PIPE     = 1'b0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_flush,
  tl_a_param_queue_if.slave          io_enq,
  tl_a_param_queue_if.master         io_deq,
  output logic [$clog2(DEPTH+1)-1:0] io_count
);

  localparam int BEAT_W = tl_a_beat_w(ADDR_W, SOURCE_W, DATA_W);
  localparam int PTR_W  = tl_ptr_w(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0]  enq_ptr_q, enq_ptr_d;
  logic [PTR_W-1:0]  deq_ptr_q, deq_ptr_d;
  logic              maybe_full_q, maybe_full_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ptr_match_s, empty_s, full_s, bypass_s;
  logic              enq_ready_s, deq_valid_s, do_enq_s, do_deq_s, wr_s, rd_s;
  logic [BEAT_W-1:0] enq_beat_s, ram_rdata_s, deq_beat_s;

  // Wrap by explicit compare so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = {PTR_W{1'b0}};
    end else begin
      nxt = ptr + PTR_W'(1);
    end
    return nxt;
  endfunction

  assign ptr_match_s = (enq_ptr_q == deq_ptr_q);
  assign empty_s     = ptr_match_s & ~maybe_full_q;
  assign full_s      = ptr_match_s & maybe_full_q;
  assign enq_beat_s  = {io_enq.opcode, io_enq.param, io_enq.size, io_enq.source,
                        io_enq.address, io_enq.mask, io_enq.data, io_enq.corrupt};

  // Handshake and head-beat muxing for base, pipe, flow-through and flush.
  always_comb begin
    bypass_s = 1'b0;
    if (io_flush) begin
      enq_ready_s = 1'b0;
    end else if (PIPE && full_s) begin
      enq_ready_s = io_deq.ready;
    end else begin
      enq_ready_s = ~full_s;
    end
    if (FLOW && empty_s) begin
      // Bypass is suppressed during flush: the enq side sees ready=0, so
      // presenting the beat downstream would deliver a beat the client retries.
      bypass_s    = 1'b1;
      deq_valid_s = io_enq.valid & ~io_flush;
      deq_beat_s  = enq_beat_s;
    end else begin
      deq_valid_s = ~empty_s;
      deq_beat_s  = ram_rdata_s;
    end
  end

  assign do_enq_s = io_enq.valid & enq_ready_s;
  assign do_deq_s = deq_valid_s & io_deq.ready;
  // A bypassed beat touches neither storage nor pointers.
  assign wr_s     = do_enq_s & ~(bypass_s & do_deq_s);
  assign rd_s     = do_deq_s & ~bypass_s;

  // Next-state for pointers, full flag and occupancy count.
  always_comb begin
    if (io_flush) begin
      enq_ptr_d    = {PTR_W{1'b0}};
      deq_ptr_d    = {PTR_W{1'b0}};
      maybe_full_d = 1'b0;
      count_d      = {CNT_W{1'b0}};
    end else begin
      if (wr_s) begin
        enq_ptr_d = ptr_inc(enq_ptr_q);
      end else begin
        enq_ptr_d = enq_ptr_q;
      end
      if (rd_s) begin
        deq_ptr_d = ptr_inc(deq_ptr_q);
      end else begin
        deq_ptr_d = deq_ptr_q;
      end
      if (wr_s != rd_s) begin
        maybe_full_d = wr_s;
        count_d      = wr_s ? (count_q + CNT_W'(1)) : (count_q - CNT_W'(1));
      end else begin
        maybe_full_d = maybe_full_q;
        count_d      = count_q;
      end
    end
  end

  // Queue state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enq_ptr_q    <= {PTR_W{1'b0}};
      deq_ptr_q    <= {PTR_W{1'b0}};
      maybe_full_q <= 1'b0;
      count_q      <= {CNT_W{1'b0}};
    end else begin
      enq_ptr_q    <= enq_ptr_d;
      deq_ptr_q    <= deq_ptr_d;
      maybe_full_q <= maybe_full_d;
      count_q      <= count_d;
    end
  end

  tl_a_param_queue_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (BEAT_W),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clock   (clock),
    .we_i    (wr_s),
    .waddr_i (enq_ptr_q),
    .wdata_i (enq_beat_s),
    .raddr_i (deq_ptr_q),
    .rdata_o (ram_rdata_s)
  );

  assign io_enq.ready = enq_ready_s;
  assign io_deq.valid = deq_valid_s;
  assign {io_deq.opcode, io_deq.param, io_deq.size, io_deq.source,
          io_deq.address, io_deq.mask, io_deq.data, io_deq.corrupt} = deq_beat_s;
  assign io_count = count_q;

endmodule

// File: tb/tb_tl_a_param_queue.sv
// tb_tl_a_param_queue
//  Directed self-checking bench. Four queue instances share clock and reset:
//  d3 (DEPTH=3 base), d2 (DEPTH=2 base), fl (DEPTH=2 FLOW), pp (DEPTH=2 PIPE).
module tb_tl_a_param_queue;
  import tl_a_param_queue_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  tl_a_param_queue_if enq_d3 (); tl_a_param_queue_if deq_d3 ();
  tl_a_param_queue_if enq_d2 (); tl_a_param_queue_if deq_d2 ();
  tl_a_param_queue_if enq_fl (); tl_a_param_queue_if deq_fl ();
  tl_a_param_queue_if enq_pp (); tl_a_param_queue_if deq_pp ();

  logic flush_d3 = 1'b0, flush_d2 = 1'b0, flush_fl = 1'b0, flush_pp = 1'b0;
  logic [1:0] count_d3, count_d2, count_fl, count_pp;
  a_chan_t beat_d3, beat_d2, beat_fl, beat_pp;
  a_chan_t out_d3, out_d2, out_fl, out_pp;

  assign {enq_d3.opcode, enq_d3.param, enq_d3.size, enq_d3.source, enq_d3.address, enq_d3.mask, enq_d3.data, enq_d3.corrupt} = beat_d3;
  assign {enq_d2.opcode, enq_d2.param, enq_d2.size, enq_d2.source, enq_d2.address, enq_d2.mask, enq_d2.data, enq_d2.corrupt} = beat_d2;
  assign {enq_fl.opcode, enq_fl.param, enq_fl.size, enq_fl.source, enq_fl.address, enq_fl.mask, enq_fl.data, enq_fl.corrupt} = beat_fl;
  assign {enq_pp.opcode, enq_pp.param, enq_pp.size, enq_pp.source, enq_pp.address, enq_pp.mask, enq_pp.data, enq_pp.corrupt} = beat_pp;
  assign out_d3 = {deq_d3.opcode, deq_d3.param, deq_d3.size, deq_d3.source, deq_d3.address, deq_d3.mask, deq_d3.data, deq_d3.corrupt};
  assign out_d2 = {deq_d2.opcode, deq_d2.param, deq_d2.size, deq_d2.source, deq_d2.address, deq_d2.mask, deq_d2.data, deq_d2.corrupt};
  assign out_fl = {deq_fl.opcode, deq_fl.param, deq_fl.size, deq_fl.source, deq_fl.address, deq_fl.mask, deq_fl.data, deq_fl.corrupt};
  assign out_pp = {deq_pp.opcode, deq_pp.param, deq_pp.size, deq_pp.source, deq_pp.address, deq_pp.mask, deq_pp.data, deq_pp.corrupt};

  tl_a_param_queue #(.DEPTH(3)) u_d3 (
    .clock(clock), .reset(reset), .io_flush(flush_d3), .io_enq(enq_d3), .io_deq(deq_d3), .io_count(count_d3));
  tl_a_param_queue #(.DEPTH(2)) u_d2 (
    .clock(clock), .reset(reset), .io_flush(flush_d2), .io_enq(enq_d2), .io_deq(deq_d2), .io_count(count_d2));
  tl_a_param_queue #(.DEPTH(2), .FLOW(1'b1)) u_fl (
    .clock(clock), .reset(reset), .io_flush(flush_fl), .io_enq(enq_fl), .io_deq(deq_fl), .io_count(count_fl));
  tl_a_param_queue #(.DEPTH(2), .PIPE(1'b1)) u_pp (
    .clock(clock), .reset(reset), .io_flush(flush_pp), .io_enq(enq_pp), .io_deq(deq_pp), .io_count(count_pp));

  // Distinct, recognisable beat for index n.
  function automatic a_chan_t mk_beat(input int n);
    a_chan_t b;
    b.opcode  = 3'(n % 7);
    b.param   = 3'(n % 8);
    b.size    = 3'd3;
    b.source  = 3'((n * 3) % 8);
    b.address = 33'h1_0000_0000 + 33'(n * 64);
    b.mask    = 8'(n * 37);
    b.data    = {32'hC0DE_0000 + 32'(n), 32'(n * 7919)};
    b.corrupt = 1'(n % 2);
    return b;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    vectors++; if ({count_d3, count_d2, count_fl, count_pp} !== 8'h00) begin miscompares++; $display("FAIL reset_count: got %h want 00", {count_d3, count_d2, count_fl, count_pp}); end
    vectors++; if ({deq_d3.valid, deq_d2.valid, deq_fl.valid, deq_pp.valid} !== 4'b0000) begin miscompares++; $display("FAIL reset_deq_valid: got %b want 0000", {deq_d3.valid, deq_d2.valid, deq_fl.valid, deq_pp.valid}); end
    vectors++; if ({enq_d3.ready, enq_d2.ready, enq_fl.ready, enq_pp.ready} !== 4'b1111) begin miscompares++; $display("FAIL reset_enq_ready: got %b want 1111", {enq_d3.ready, enq_d2.ready, enq_fl.ready, enq_pp.ready}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_enq();
    a_chan_t first;
    first = mk_beat(1);
    first.opcode  = TL_GET;
    first.address = 33'h1_0000_0040;
    first.source  = 3'd5;
    beat_d3 = first; enq_d3.valid = 1'b1; deq_d3.ready = 1'b0;
    #1;
    vectors++; if (deq_d3.valid !== 1'b0) begin miscompares++; $display("FAIL single_same_cycle_valid: got %b want 0", deq_d3.valid); end
    tick();
    enq_d3.valid = 1'b0;
    #1;
    vectors++; if (deq_d3.valid !== 1'b1) begin miscompares++; $display("FAIL single_deq_valid: got %b want 1", deq_d3.valid); end
    vectors++; if (out_d3 !== first) begin miscompares++; $display("FAIL single_bits: got %h want %h", out_d3, first); end
    vectors++; if (count_d3 !== 2'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", count_d3); end
    deq_d3.ready = 1'b1;
    tick();
    deq_d3.ready = 1'b0;
    #1;
    vectors++; if (count_d3 !== 2'd0 || deq_d3.valid !== 1'b0) begin miscompares++; $display("FAIL single_drain: got count %0d valid %b want 0 0", count_d3, deq_d3.valid); end
  endtask

  task automatic test_fill_drain();
    deq_d3.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat_d3 = mk_beat(10 + i); enq_d3.valid = 1'b1;
      tick();
      vectors++; if (count_d3 !== 2'(i + 1)) begin miscompares++; $display("FAIL fill_count_%0d: got %0d want %0d", i, count_d3, i + 1); end
    end
    enq_d3.valid = 1'b0;
    #1;
    vectors++; if (enq_d3.ready !== 1'b0) begin miscompares++; $display("FAIL full_enq_ready: got %b want 0", enq_d3.ready); end
    deq_d3.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (deq_d3.valid !== 1'b1 || out_d3 !== mk_beat(10 + i) || count_d3 !== 2'(3 - i)) begin
        miscompares++; $display("FAIL drain_%0d: got valid %b count %0d bits %h want 1 %0d %h", i, deq_d3.valid, count_d3, out_d3, 3 - i, mk_beat(10 + i));
      end
      tick();
    end
    deq_d3.ready = 1'b0;
    #1;
    vectors++; if (deq_d3.valid !== 1'b0 || count_d3 !== 2'd0 || enq_d3.ready !== 1'b1) begin miscompares++; $display("FAIL drain_empty: got valid %b count %0d ready %b want 0 0 1", deq_d3.valid, count_d3, enq_d3.ready); end
  endtask

  task automatic test_back_to_back();
    deq_d2.ready = 1'b1; beat_d2 = mk_beat(20); enq_d2.valid = 1'b1;
    #1;
    vectors++; if (deq_d2.valid !== 1'b0) begin miscompares++; $display("FAIL b2b_first_valid: got %b want 0", deq_d2.valid); end
    tick();
    for (int k = 1; k <= 20; k++) begin
      if (k < 20) beat_d2 = mk_beat(20 + k);
      else enq_d2.valid = 1'b0;
      #1;
      vectors++; if (deq_d2.valid !== 1'b1 || out_d2 !== mk_beat(19 + k) || count_d2 !== 2'd1 || enq_d2.ready !== 1'b1) begin
        miscompares++; $display("FAIL b2b_beat_%0d: got valid %b ready %b count %0d bits %h want 1 1 1 %h", k, deq_d2.valid, enq_d2.ready, count_d2, out_d2, mk_beat(19 + k));
      end
      tick();
    end
    deq_d2.ready = 1'b0;
    vectors++; if (count_d2 !== 2'd0 || deq_d2.valid !== 1'b0) begin miscompares++; $display("FAIL b2b_end: got count %0d valid %b want 0 0", count_d2, deq_d2.valid); end
  endtask

  task automatic test_flow();
    beat_fl = mk_beat(50); enq_fl.valid = 1'b1; deq_fl.ready = 1'b1;
    #1;
    vectors++; if (deq_fl.valid !== 1'b1 || out_fl !== mk_beat(50) || enq_fl.ready !== 1'b1) begin miscompares++; $display("FAIL flow_bypass: got valid %b ready %b bits %h want 1 1 %h", deq_fl.valid, enq_fl.ready, out_fl, mk_beat(50)); end
    tick();
    enq_fl.valid = 1'b0;
    #1;
    vectors++; if (count_fl !== 2'd0 || deq_fl.valid !== 1'b0) begin miscompares++; $display("FAIL flow_no_store: got count %0d valid %b want 0 0", count_fl, deq_fl.valid); end
    beat_fl = mk_beat(51); enq_fl.valid = 1'b1; deq_fl.ready = 1'b0;
    tick();
    enq_fl.valid = 1'b0;
    #1;
    vectors++; if (count_fl !== 2'd1 || deq_fl.valid !== 1'b1 || out_fl !== mk_beat(51)) begin miscompares++; $display("FAIL flow_not_taken: got count %0d valid %b bits %h want 1 1 %h", count_fl, deq_fl.valid, out_fl, mk_beat(51)); end
    deq_fl.ready = 1'b1;
    tick();
    deq_fl.ready = 1'b0;
    #1;
    vectors++; if (count_fl !== 2'd0) begin miscompares++; $display("FAIL flow_drain: got count %0d want 0", count_fl); end
  endtask

  task automatic test_pipe();
    deq_pp.ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      beat_pp = mk_beat(60 + i); enq_pp.valid = 1'b1;
      tick();
    end
    enq_pp.valid = 1'b0;
    #1;
    vectors++; if (count_pp !== 2'd2 || enq_pp.ready !== 1'b0) begin miscompares++; $display("FAIL pipe_full: got count %0d ready %b want 2 0", count_pp, enq_pp.ready); end
    deq_pp.ready = 1'b1; beat_pp = mk_beat(62); enq_pp.valid = 1'b1;
    #1;
    vectors++; if (enq_pp.ready !== 1'b1 || deq_pp.valid !== 1'b1 || out_pp !== mk_beat(60)) begin miscompares++; $display("FAIL pipe_ready_follow: got ready %b valid %b bits %h want 1 1 %h", enq_pp.ready, deq_pp.valid, out_pp, mk_beat(60)); end
    tick();
    beat_pp = mk_beat(63);
    #1;
    vectors++; if (count_pp !== 2'd2 || out_pp !== mk_beat(61) || enq_pp.ready !== 1'b1) begin miscompares++; $display("FAIL pipe_step1: got count %0d ready %b bits %h want 2 1 %h", count_pp, enq_pp.ready, out_pp, mk_beat(61)); end
    tick();
    enq_pp.valid = 1'b0;
    #1;
    vectors++; if (count_pp !== 2'd2 || out_pp !== mk_beat(62)) begin miscompares++; $display("FAIL pipe_step2: got count %0d bits %h want 2 %h", count_pp, out_pp, mk_beat(62)); end
    tick();
    vectors++; if (count_pp !== 2'd1 || out_pp !== mk_beat(63)) begin miscompares++; $display("FAIL pipe_step3: got count %0d bits %h want 1 %h", count_pp, out_pp, mk_beat(63)); end
    tick();
    deq_pp.ready = 1'b0;
    vectors++; if (count_pp !== 2'd0 || deq_pp.valid !== 1'b0) begin miscompares++; $display("FAIL pipe_end: got count %0d valid %b want 0 0", count_pp, deq_pp.valid); end
  endtask

  task automatic test_flush();
    deq_d3.ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      beat_d3 = mk_beat(70 + i); enq_d3.valid = 1'b1;
      tick();
    end
    vectors++; if (count_d3 !== 2'd2) begin miscompares++; $display("FAIL flush_pre_count: got %0d want 2", count_d3); end
    flush_d3 = 1'b1; beat_d3 = mk_beat(72);
    #1;
    vectors++; if (enq_d3.ready !== 1'b0 || deq_d3.valid !== 1'b1 || out_d3 !== mk_beat(70)) begin miscompares++; $display("FAIL flush_cycle: got ready %b valid %b bits %h want 0 1 %h", enq_d3.ready, deq_d3.valid, out_d3, mk_beat(70)); end
    tick();
    flush_d3 = 1'b0; enq_d3.valid = 1'b0;
    #1;
    vectors++; if (count_d3 !== 2'd0 || deq_d3.valid !== 1'b0 || enq_d3.ready !== 1'b1) begin miscompares++; $display("FAIL flush_after: got count %0d valid %b ready %b want 0 0 1", count_d3, deq_d3.valid, enq_d3.ready); end
    beat_d3 = mk_beat(73); enq_d3.valid = 1'b1;
    tick();
    enq_d3.valid = 1'b0;
    #1;
    vectors++; if (count_d3 !== 2'd1 || out_d3 !== mk_beat(73)) begin miscompares++; $display("FAIL flush_restart: got count %0d bits %h want 1 %h", count_d3, out_d3, mk_beat(73)); end
    deq_d3.ready = 1'b1;
    tick();
    deq_d3.ready = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    for (int i = 0; i < 2; i++) begin
      beat_d3 = mk_beat(80 + i); enq_d3.valid = 1'b1;
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (count_d3 !== 2'd0 || deq_d3.valid !== 1'b0 || enq_d3.ready !== 1'b1) begin miscompares++; $display("FAIL reset_mid: got count %0d valid %b ready %b want 0 0 1", count_d3, deq_d3.valid, enq_d3.ready); end
    tick();
    reset = 1'b0; enq_d3.valid = 1'b0;
    tick();
    vectors++; if (count_d3 !== 2'd0 || deq_d3.valid !== 1'b0) begin miscompares++; $display("FAIL reset_mid_after: got count %0d valid %b want 0 0", count_d3, deq_d3.valid); end
  endtask

  initial begin
    enq_d3.valid = 1'b0; enq_d2.valid = 1'b0; enq_fl.valid = 1'b0; enq_pp.valid = 1'b0;
    deq_d3.ready = 1'b0; deq_d2.ready = 1'b0; deq_fl.ready = 1'b0; deq_pp.ready = 1'b0;
    beat_d3 = mk_beat(0); beat_d2 = mk_beat(0); beat_fl = mk_beat(0); beat_pp = mk_beat(0);
    test_reset();
    test_single_enq();
    test_fill_drain();
    test_back_to_back();
    test_flow();
    test_pipe();
    test_flush();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
